// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA sink timing defaults and shared types
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic {
    ALIGN  = 1'b0,
    LOCKED = 1'b1
  } sink_state_t;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters and VGA timing decode
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic clk,
  input  logic reset,
  output logic active,
  output logic first_px,
  output logic last_px,
  output logic hs_raw,
  output logic vs_raw
);
  import vga_pkg::*;

  localparam int HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;

  assign h_wrap = (h_cnt == HW'(HTOT - 1));
  assign v_wrap = (v_cnt == VW'(VTOT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active   = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign first_px = (h_cnt == '0) && (v_cnt == '0);
  assign last_px  = (h_cnt == HW'(H_ACTIVE - 1)) && (v_cnt == VW'(V_ACTIVE - 1));
  assign hs_raw   = !((h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw   = !((v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));

endmodule

// File: rtl/vga_stream_sink.sv
// rtl/vga_stream_sink.sv - paces a one-frame-per-packet RGB444 stream onto VGA pins
module vga_stream_sink #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] data_in,
  input  logic        sop_in,
  input  logic        eop_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        locked,
  output logic        sync_err
);
  import vga_pkg::*;

  logic        active, first_px, last_px, hs_raw, vs_raw;
  sink_state_t state, state_nxt;
  logic        ready, show, err_nxt;
  rgb444_t     pix;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .active   (active),
    .first_px (first_px),
    .last_px  (last_px),
    .hs_raw   (hs_raw),
    .vs_raw   (vs_raw)
  );

  // While locked, blanking simply stalls upstream; a waiting sop is not a fault there.
  always_comb begin
    ready     = 1'b0;
    show      = 1'b0;
    err_nxt   = 1'b0;
    state_nxt = state;
    case (state)
      ALIGN: begin
        ready = !(valid_in && sop_in);
        if (first_px && valid_in && sop_in) begin
          ready     = 1'b1;
          show      = 1'b1;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (active) begin
          ready = 1'b1;
          if (!valid_in) begin
            err_nxt   = 1'b1;
            state_nxt = ALIGN;
          end else if (sop_in && !first_px) begin
            ready     = 1'b0;
            err_nxt   = 1'b1;
            state_nxt = ALIGN;
          end else begin
            show = 1'b1;
            if ((first_px && !sop_in) || (eop_in && !last_px) || (last_px && !eop_in)) begin
              err_nxt   = 1'b1;
              state_nxt = ALIGN;
            end
          end
        end
      end
      default: state_nxt = ALIGN;
    endcase
  end

  assign ready_out = ready && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ALIGN;
      pix         <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pix         <= show ? rgb444_t'(data_in) : '0;
      vga_hs      <= hs_raw;
      vga_vs      <= vs_raw;
      vga_blank_n <= active;
      sync_err    <= err_nxt;
    end
  end

  assign vga_r  = pix.r;
  assign vga_g  = pix.g;
  assign vga_b  = pix.b;
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_stream_sink.sv
// tb/tb_vga_stream_sink.sv - randomized directed bench for vga_stream_sink on a reduced raster
module tb_vga_stream_sink;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int NPIX = HA * VA;

  typedef struct packed {
    logic [11:0] d;
    logic        s;
    logic        e;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] data_in = '0;
  logic        sop_in = 1'b0, eop_in = 1'b0, valid_in = 1'b0;
  logic        ready_out;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, locked, sync_err;

  int    checks = 0, errors = 0;
  beat_t q[$];
  int    pos = 0, drop_pos = -1;
  bit    m_locked = 1'b0;
  int    err_cnt = 0, hs_low = 0, vs_low = 0, blank_hi = 0;

  always #5 clk = ~clk;

  vga_stream_sink #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
    .valid_in(valid_in), .ready_out(ready_out), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .locked(locked),
    .sync_err(sync_err)
  );

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(bit rnd, int npix);
    for (int i = 0; i < npix; i++) begin
      beat_t b;
      b.d = rnd ? 12'($urandom) : 12'(((i % HA) + (i / HA)) & 'hFFF);
      b.s = (i == 0);
      b.e = (i == npix - 1);
      q.push_back(b);
    end
  endtask

  // Upstream source plus expectation: while locked, active pixel k of the raster must
  // carry beat k of the packet, with sop exactly at k==0 and eop exactly at k==NPIX-1.
  task automatic cycle();
    int    x, y, k;
    bit    v, act, er, sh, ee, nl, consumed;
    beat_t b;
    @(negedge clk);
    x   = pos % HT;
    y   = pos / HT;
    k   = y * HA + x;
    act = (x < HA) && (y < VA);
    v   = (q.size() > 0) && (pos != drop_pos);
    if (v) b = q[0];
    else begin
      b.d = 12'($urandom);
      b.s = 1'($urandom);
      b.e = 1'($urandom);
    end
    valid_in = v;
    data_in  = b.d;
    sop_in   = b.s;
    eop_in   = b.e;
    sh = 1'b0;
    ee = 1'b0;
    nl = m_locked;
    if (!m_locked) begin
      er = !(v && b.s) || (pos == 0);
      if (v && b.s && pos == 0) begin
        sh = 1'b1;
        nl = 1'b1;
      end
    end else if (act) begin
      consumed = v && !(b.s && k != 0);
      er = !(v && b.s && k != 0);
      sh = consumed;
      if (!consumed || (b.s != (k == 0)) || (b.e != (k == NPIX - 1))) begin
        ee = 1'b1;
        nl = 1'b0;
      end
    end else begin
      er = 1'b0;
    end
    #1 chk("ready_out", 32'(ready_out), 32'(er));
    @(posedge clk);
    if (v && er) q.delete(0);
    m_locked = nl;
    pos = (pos + 1) % FT;
    #1;
    chk("rgb", 32'({vga_r, vga_g, vga_b}), sh ? 32'(b.d) : 0);
    chk("blank_n", 32'(vga_blank_n), 32'(act));
    chk("hs", 32'(vga_hs), 32'(!(x >= HA + HF && x < HA + HF + HS)));
    chk("vs", 32'(vga_vs), 32'(!(y >= VA + VF && y < VA + VF + VS)));
    chk("sync_err", 32'(sync_err), 32'(ee));
    chk("locked", 32'(locked), 32'(nl));
    err_cnt  += int'(sync_err);
    hs_low   += int'(!vga_hs);
    vs_low   += int'(!vga_vs);
    blank_hi += int'(vga_blank_n);
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values, with a sop offered so the ready gate is exercised
    valid_in = 1'b1;
    sop_in   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    chk("rst_hs", 32'(vga_hs), 1);
    chk("rst_vs", 32'(vga_vs), 1);
    chk("rst_blank_n", 32'(vga_blank_n), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    chk("rst_ready", 32'(ready_out), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    valid_in = 1'b0;

    // idle raster timing
    run(FT);
    hs_low = 0; vs_low = 0; blank_hi = 0;
    run(FT);
    chk("idle_hs_low_clocks", hs_low, HS * VT);
    chk("idle_vs_low_clocks", vs_low, VS * HT);
    chk("idle_active_clocks", blank_hi, NPIX);

    // stream starts mid-frame: sop held to (0,0), then three back-to-back frames
    run(100);
    push_frame(1'b0, NPIX);
    push_frame(1'b0, NPIX);
    push_frame(1'b1, NPIX);
    err_cnt = 0;
    run(FT - 100 + 3 * FT);
    chk("cont_sync_errs", err_cnt, 0);
    chk("cont_all_consumed", q.size(), 0);
    chk("cont_locked", 32'(locked), 1);

    // underflow mid-frame, relock on next frame
    err_cnt = 0;
    push_frame(1'b1, NPIX);
    push_frame(1'b1, NPIX);
    drop_pos = 3 * HT + 5;
    run(FT);
    drop_pos = -1;
    chk("uf_sync_errs", err_cnt, 1);
    chk("uf_unlocked", 32'(locked), 0);
    chk("uf_next_frame_intact", q.size(), NPIX);
    run(FT);
    chk("uf_relock_consumed", q.size(), 0);
    chk("uf_relocked", 32'(locked), 1);
    chk("uf_no_more_errs", err_cnt, 1);

    // early eop on the second-to-last line
    err_cnt = 0;
    push_frame(1'b1, (VA - 1) * HA);
    push_frame(1'b1, NPIX);
    run(FT);
    chk("eop_sync_errs", err_cnt, 1);
    chk("eop_unlocked", 32'(locked), 0);
    chk("eop_next_frame_held", q.size(), NPIX);
    run(FT);
    chk("eop_relock_consumed", q.size(), 0);
    chk("eop_relocked", 32'(locked), 1);

    // asynchronous reset mid-line while locked
    push_frame(1'b1, NPIX);
    run(4 * HT + 7);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    chk("mid_rst_hs", 32'(vga_hs), 1);
    chk("mid_rst_vs", 32'(vga_vs), 1);
    chk("mid_rst_blank_n", 32'(vga_blank_n), 0);
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_sync_err", 32'(sync_err), 0);
    chk("mid_rst_ready", 32'(ready_out), 0);
    repeat (3) @(posedge clk);
    #1 chk("mid_rst_ready_held", 32'(ready_out), 0);
    #1 reset = 1'b1;
    pos = 0;
    m_locked = 1'b0;
    err_cnt = 0;
    run(FT);
    chk("post_rst_discarded", q.size(), 0);
    chk("post_rst_no_errs", err_cnt, 0);
    chk("post_rst_unlocked", 32'(locked), 0);
    push_frame(1'b0, NPIX);
    run(FT);
    chk("post_rst_consumed", q.size(), 0);
    chk("post_rst_locked", 32'(locked), 1);
    chk("post_rst_errs", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_stream_sink.md
Name: vga_stream_sink

Overview:
- Terminal stage of the pixel pipeline. Consumes the 12-bit RGB444 packet stream from the last filter in the chain.
- Paces the stream against internally generated VGA timing and drives the VGA DAC pins.
- One packet is one frame: sop on the first pixel, eop on the last, raster order.
- Owns frame alignment and recovery after upstream underflow or a malformed packet.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  in  1  pixel clock (25 MHz nominal)
reset  in  1  asynchronous, active-low
data_in  in  12  pixel {R[11:8],G[7:4],B[3:0]}
sop_in  in  1  first pixel of frame
eop_in  in  1  last pixel of frame
valid_in  in  1  data_in/sop_in/eop_in valid
ready_out  out  1  back pressure to upstream; beat transfers when valid_in && ready_out
vga_r, vga_g, vga_b  out  4 each  colour to DAC
vga_hs, vga_vs  out  1 each  sync, active-low
vga_blank_n  out  1  high during active video
locked  out  1  level; stream aligned to raster
sync_err  out  1  one-cycle pulse on any alignment fault

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, with H_TOTAL = sum of the H parameters (800). v_cnt runs 0..V_TOTAL-1 (525).
  - v_cnt increments when h_cnt wraps. Both wrap to 0 together at (799,524).
  - Counter width is clog2(total), 10 bits at defaults.
- Timing decode:
  - active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
  - hs_raw low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - first_px = (h_cnt==0 && v_cnt==0). last_px = (h_cnt==H_ACTIVE-1 && v_cnt==V_ACTIVE-1).
- Outputs: all VGA outputs are registered, one-cycle latency from counters, so pins for counter position N appear on the cycle after N.
  - vga_blank_n <= active.
  - RGB <= data_in if the beat is accepted in an active cycle, else 0.
- State machine: states ALIGN and LOCKED. Reset state is ALIGN.
- ALIGN:
  - ready_out = !(valid_in && sop_in). Non-sop beats are discarded; the sop beat is held, not consumed.
  - When first_px && valid_in && sop_in: ready_out=1, the beat is accepted and displayed, and the state moves to LOCKED.
  - Otherwise active pixels output black.
  - locked = 0.
- LOCKED:
  - Base rule: ready_out = active, except the sop cases below.
  - Underflow (active && !valid_in): output black, pulse sync_err, go to ALIGN.
  - valid_in && sop_in && !first_px: ready_out=0 (sop held), black, pulse sync_err, go to ALIGN.
  - first_px && valid_in && !sop_in: beat consumed and displayed, pulse sync_err, go to ALIGN.
  - Accepted eop_in && !last_px (early eop): pulse sync_err, go to ALIGN.
  - last_px accepted without eop_in: pulse sync_err, go to ALIGN.
  - Faults take priority in the order listed. At most one sync_err pulse per cycle.
- Blanking: ready_out = 0 outside active in every state except the ALIGN discard path. Upstream stalls through blanking.
- Reset: while reset is low, ready_out = 0 (combinational gate).
- Reset values:
  - vga_r/g/b = 0, vga_hs = 1, vga_vs = 1, vga_blank_n = 0.
  - locked = 0, sync_err = 0, h_cnt = v_cnt = 0, state = ALIGN.
- Mid-frame reset: raster restarts at (0,0) on the first clock after deassertion; re-alignment proceeds normally.

Decomposition:
- Package vga_pkg:
  - timing constants (defaults above)
  - H_TOTAL/V_TOTAL
  - typedef rgb444_t (struct r,g,b 4-bit)
  - enum sink_state_t {ALIGN, LOCKED}
- Sub-module vga_timing_gen:
  - Owns the counters and decode.
  - Outputs active, first_px, last_px, hs_raw, vs_raw.
  - Reused by any later overlay stage.

Test Plan:
- Reset release, no stream → hs low for h_cnt 656..751 (96 clocks, line period 800); vs low for 2 lines every 525; RGB 0, blank_n follows active, locked=0.
- Continuous valid 640x480 packets, pixel value = (x+y)&0xFFF, sop/eop correct → locked=1 from the first accepted pixel; pin RGB at active cycle (x,y) equals (x+y)&0xFFF one clock later; ready_out=0 for all 160 blanking clocks per line; sync_err never asserts.
- Stream starts mid-frame with sop → sop held (ready_out=0) until (0,0), consumed there, locked=1; no pixels lost from the packet.
- While LOCKED, drop valid_in at (100,20) → black pixel, sync_err 1-cycle pulse, locked=0; the rest of the packet is discarded; relock at the next frame's sop at (0,0).
- Early eop at (639,478) → sync_err, ALIGN; the next sop is held until (0,0).
- Assert reset mid-line at (300,200) for 3 clocks → outputs return to reset values asynchronously; ready_out=0; after release h_cnt=v_cnt=0 and ALIGN.
